// File: rtl/cci_test_run_ctrl.sv
// -----------------------------------------------------------------------------
// cci_test_run_ctrl
//   Test run controller that sits behind the generic test CSR manager. A write
//   to the control CSR starts, aborts or clears a run; the length CSR sets how
//   many request slots a run issues. A run walks IDLE -> RUN -> DRAIN -> DONE,
//   issuing at most one request per cycle (held off by TX almost-full) and
//   counting retired response lines until everything issued has come back or
//   the drain timeout expires.
//
// Ports
//   clk           single clock, all state on posedge
//   reset_n       asynchronous active-low reset
//   wr_ctrl_en    control CSR write strobe: wr_data[0]=start [1]=abort [2]=clear
//   wr_len_en     length CSR write strobe: num_reqs = wr_data[CNT_W-1:0]
//   wr_data       shared 64-bit CSR write data
//   req_alm_full  TX almost-full, blocks issue while high
//   rsp_lines     response lines retired this cycle (0..4)
//   req_valid     issue one request this cycle
//   req_idx       0-based index of the request being issued
//   busy          run in progress (RUN or DRAIN)
//   done          run finished (DONE)
//   rd_status     registered status word:
//                   [0] busy [1] done [2] timeout [3] aborted [4] rsp_ovf
//                   [6:5] state [31:7] 0 [63:32] completed
//   rd_cycles     registered count of cycles spent in RUN+DRAIN
// -----------------------------------------------------------------------------
module cci_test_run_ctrl #(
    parameter int CNT_W         = 32,
    parameter int DRAIN_TIMEOUT = 4096
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             wr_ctrl_en,
    input  logic             wr_len_en,
    input  logic [63:0]      wr_data,
    input  logic             req_alm_full,
    input  logic [2:0]       rsp_lines,
    output logic             req_valid,
    output logic [CNT_W-1:0] req_idx,
    output logic             busy,
    output logic             done,
    output logic [63:0]      rd_status,
    output logic [63:0]      rd_cycles
);

    // Drain counter only has to reach DRAIN_TIMEOUT-1 before the forced exit.
    localparam int              TO_W    = (DRAIN_TIMEOUT > 1) ? $clog2(DRAIN_TIMEOUT) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(DRAIN_TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;

    logic [CNT_W-1:0] r_num_reqs;
    logic [CNT_W-1:0] r_issued;
    logic [CNT_W-1:0] r_completed;
    logic [CNT_W-1:0] r_cycles;
    logic [TO_W-1:0]  r_drain_cnt;
    logic             r_timeout;
    logic             r_aborted;
    logic             r_rsp_ovf;
    logic [63:0]      r_rd_status;
    logic [63:0]      r_rd_cycles;

    logic             w_start;
    logic             w_abort;
    logic             w_clear;
    logic             w_idle_or_done;
    logic             w_launch;
    logic             w_clear_ok;
    logic             w_abort_ok;
    logic             w_issue;
    logic             w_busy;
    logic [CNT_W-1:0] w_issued_nxt;
    logic [CNT_W:0]   w_rsp_sum;
    logic             w_rsp_ovf;
    logic [CNT_W-1:0] w_completed_nxt;
    logic             w_drained;
    logic             w_to_hit;
    logic             w_unused_wr;

    // Only the low bits of the write data are decoded.
    assign w_unused_wr = &{1'b0, wr_data};

    // ---------------------------------------------------------------- decode
    assign w_start        = wr_ctrl_en & wr_data[0];
    assign w_abort        = wr_ctrl_en & wr_data[1];
    assign w_clear        = wr_ctrl_en & wr_data[2];
    assign w_idle_or_done = (r_state == ST_IDLE) || (r_state == ST_DONE);
    assign w_busy         = (r_state == ST_RUN) || (r_state == ST_DRAIN);
    assign w_launch       = w_start && w_idle_or_done;
    // start wins over clear when both bits are set in one write
    assign w_clear_ok     = w_clear && !w_start && (r_state == ST_DONE);
    assign w_abort_ok     = w_abort && (r_state == ST_RUN);

    // An abort write suppresses issue in that same cycle.
    assign w_issue      = (r_state == ST_RUN) && !req_alm_full &&
                          (r_issued < r_num_reqs) && !w_abort_ok;
    assign w_issued_nxt = r_issued + CNT_W'(w_issue);

    // Response accounting against the already-registered issue count; one
    // spare bit so the overflow compare cannot wrap.
    assign w_rsp_sum       = {1'b0, r_completed} + (CNT_W+1)'(rsp_lines);
    assign w_rsp_ovf       = (r_state != ST_IDLE) && (w_rsp_sum > {1'b0, r_issued});
    assign w_completed_nxt = (r_state == ST_IDLE) ? r_completed :
                             w_rsp_ovf            ? r_issued    :
                                                    w_rsp_sum[CNT_W-1:0];

    // Drain completes on the post-update outstanding count.
    assign w_drained = (r_issued == w_completed_nxt);
    assign w_to_hit  = (r_drain_cnt == TO_LAST);

    // ------------------------------------------------------ state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------ next state
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (w_start) begin
                    w_state_nxt = (r_num_reqs == '0) ? ST_DONE : ST_RUN;
                end else if (w_clear_ok) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_RUN: begin
                // Also leave RUN if there is nothing left to issue at all.
                if (w_abort_ok ||
                    (w_issue && (w_issued_nxt == r_num_reqs)) ||
                    (r_issued >= r_num_reqs)) begin
                    w_state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (w_drained || w_to_hit) begin
                    w_state_nxt = ST_DONE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------ outputs
    always_comb begin
        req_valid = w_issue;
        req_idx   = r_issued;
        busy      = w_busy;
        done      = (r_state == ST_DONE);
    end

    assign rd_status = r_rd_status;
    assign rd_cycles = r_rd_cycles;

    // ------------------------------------------------------ datapath
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_num_reqs  <= '0;
            r_issued    <= '0;
            r_completed <= '0;
            r_cycles    <= '0;
            r_drain_cnt <= '0;
            r_timeout   <= 1'b0;
            r_aborted   <= 1'b0;
            r_rsp_ovf   <= 1'b0;
            r_rd_status <= '0;
            r_rd_cycles <= '0;
        end else begin
            // Length is frozen for the duration of a run.
            if (wr_len_en && !w_busy) begin
                r_num_reqs <= wr_data[CNT_W-1:0];
            end

            if (w_launch || w_clear_ok) begin
                r_issued    <= '0;
                r_completed <= '0;
                r_cycles    <= '0;
                r_drain_cnt <= '0;
                r_timeout   <= 1'b0;
                r_aborted   <= 1'b0;
                r_rsp_ovf   <= 1'b0;
            end else begin
                r_issued    <= w_issued_nxt;
                r_completed <= w_completed_nxt;

                // Sticky: more lines than were ever issued, or any in IDLE.
                if (w_rsp_ovf || ((r_state == ST_IDLE) && (rsp_lines != '0))) begin
                    r_rsp_ovf <= 1'b1;
                end

                if (w_busy && (r_cycles != '1)) begin
                    r_cycles <= r_cycles + 1'b1;
                end

                if (w_abort_ok) begin
                    r_aborted <= 1'b1;
                end

                if ((r_state == ST_DRAIN) && !w_drained && w_to_hit) begin
                    r_timeout <= 1'b1;
                end

                r_drain_cnt <= (r_state == ST_DRAIN) ? r_drain_cnt + 1'b1 : '0;
            end

            // Readback words trail the live state by one cycle.
            r_rd_status <= {32'(r_completed), 25'd0, r_state, r_rsp_ovf,
                            r_aborted, r_timeout, (r_state == ST_DONE), w_busy};
            r_rd_cycles <= 64'(r_cycles);
        end
    end

endmodule

// File: tb/tb_cci_test_run_ctrl.sv
module tb_cci_test_run_ctrl;

    localparam int CNT_W = 32;
    localparam int DT    = 16;

    logic             clk;
    logic             reset_n;
    logic             wr_ctrl_en;
    logic             wr_len_en;
    logic [63:0]      wr_data;
    logic             req_alm_full;
    logic [2:0]       rsp_lines;
    logic             req_valid;
    logic [CNT_W-1:0] req_idx;
    logic             busy;
    logic             done;
    logic [63:0]      rd_status;
    logic [63:0]      rd_cycles;

    cci_test_run_ctrl #(.CNT_W(CNT_W), .DRAIN_TIMEOUT(DT)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .wr_ctrl_en   (wr_ctrl_en),
        .wr_len_en    (wr_len_en),
        .wr_data      (wr_data),
        .req_alm_full (req_alm_full),
        .rsp_lines    (rsp_lines),
        .req_valid    (req_valid),
        .req_idx      (req_idx),
        .busy         (busy),
        .done         (done),
        .rd_status    (rd_status),
        .rd_cycles    (rd_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          n_issued = 0;
    logic [63:0] exp_q[$];
    bit          auto_rsp = 1'b0;
    int          alm_lo = 1;
    int          alm_hi = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard side: every issued request pops the next expected index.
    always @(negedge clk) begin
        if (reset_n) begin
            if (req_alm_full) chk("alm_block", {63'd0, req_valid}, 64'd0);
            if (req_valid) begin
                logic [63:0] e;
                e = (exp_q.size() != 0) ? exp_q.pop_front() : 64'hFFFF_FFFF_FFFF_FFFF;
                chk("req_idx", {32'd0, req_idx}, e);
                n_issued++;
            end
        end
    end

    // One clock; with auto_rsp, a request issued this cycle retires one line
    // in the following cycle.
    task automatic tick;
        logic iv;
        #1;
        iv = req_valid;
        @(posedge clk);
        #1;
        if (auto_rsp) rsp_lines = iv ? 3'd1 : 3'd0;
    endtask

    task automatic wr_len(input logic [63:0] v);
        wr_len_en = 1'b1;
        wr_data   = v;
        tick();
        wr_len_en = 1'b0;
        wr_data   = '0;
    endtask

    task automatic wr_ctrl(input logic [63:0] v);
        wr_ctrl_en = 1'b1;
        wr_data    = v;
        tick();
        wr_ctrl_en = 1'b0;
        wr_data    = '0;
    endtask

    task automatic push_idx(input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(64'(i));
    endtask

    task automatic wait_done(input int maxc);
        int c;
        c = 0;
        while (!done && c < maxc) begin
            req_alm_full = (c >= alm_lo) && (c <= alm_hi);
            tick();
            c++;
        end
        req_alm_full = 1'b0;
        chk("done_wait", {63'd0, done}, 64'd1);
    endtask

    initial begin
        reset_n      = 1'b0;
        wr_ctrl_en   = 1'b0;
        wr_len_en    = 1'b0;
        wr_data      = '0;
        req_alm_full = 1'b0;
        rsp_lines    = '0;
        #1;
        chk("rst_req_valid", {63'd0, req_valid}, 64'd0);
        chk("rst_busy",      {63'd0, busy},      64'd0);
        chk("rst_done",      {63'd0, done},      64'd0);
        chk("rst_status",    rd_status,          64'd0);
        chk("rst_cycles",    rd_cycles,          64'd0);
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        tick();

        // len=4, free-running issue, one line back per issue
        auto_rsp = 1'b1;
        n_issued = 0;
        wr_len(64'd4);
        push_idx(4);
        wr_ctrl(64'd1);
        chk("t1_busy_n1", {63'd0, busy}, 64'd1);
        wait_done(40);
        tick();
        chk("t1_status",  rd_status, {32'd4, 32'h62});
        chk("t1_cycles",  rd_cycles, 64'd5);
        chk("t1_issued",  64'(n_issued), 64'd4);
        chk("t1_q_empty", 64'(exp_q.size()), 64'd0);

        // len=8, almost-full during run cycles 2..5
        n_issued = 0;
        wr_len(64'd8);
        push_idx(8);
        wr_ctrl(64'd1);
        alm_lo = 2;
        alm_hi = 5;
        wait_done(60);
        alm_lo = 1;
        alm_hi = 0;
        tick();
        chk("t2_status",  rd_status, {32'd8, 32'h62});
        chk("t2_cycles",  rd_cycles, 64'd13);
        chk("t2_issued",  64'(n_issued), 64'd8);
        chk("t2_q_empty", 64'(exp_q.size()), 64'd0);

        // len=0 goes straight to DONE
        n_issued = 0;
        wr_len(64'd0);
        wr_ctrl(64'd1);
        chk("t3_done", {63'd0, done}, 64'd1);
        chk("t3_busy", {63'd0, busy}, 64'd0);
        tick();
        chk("t3_status", rd_status, 64'h62);
        chk("t3_issued", 64'(n_issued), 64'd0);

        // len=100, abort after 10 issues
        n_issued = 0;
        wr_len(64'd100);
        push_idx(100);
        wr_ctrl(64'd1);
        repeat (10) tick();
        wr_ctrl_en = 1'b1;
        wr_data    = 64'd2;
        #1;
        chk("t4_abort_supp", {63'd0, req_valid}, 64'd0);
        tick();
        wr_ctrl_en = 1'b0;
        wr_data    = '0;
        chk("t4_drain", {62'd0, rd_status[6:5]}, 64'd1);
        wait_done(40);
        tick();
        chk("t4_status", rd_status, {32'd10, 32'h6A});
        chk("t4_issued", 64'(n_issued), 64'd10);
        exp_q.delete();

        // len=2, no responses: drain timeout, then late overflow lines
        auto_rsp  = 1'b0;
        rsp_lines = '0;
        n_issued  = 0;
        wr_len(64'd2);
        push_idx(2);
        wr_ctrl(64'd1);
        wait_done(DT + 20);
        tick();
        chk("t5_cycles",  rd_cycles, 64'(2 + DT));
        chk("t5_timeout", {63'd0, rd_status[2]}, 64'd1);
        rsp_lines = 3'd3;
        tick();
        rsp_lines = '0;
        tick();
        chk("t5_status",  rd_status, {32'd2, 32'h76});
        chk("t5_q_empty", 64'(exp_q.size()), 64'd0);

        // start+clear together: start wins; length write during run ignored
        auto_rsp = 1'b1;
        n_issued = 0;
        wr_len(64'd5);
        push_idx(5);
        wr_ctrl(64'd5);
        chk("t6_start_wins", {63'd0, busy}, 64'd1);
        tick();
        wr_len(64'd3);
        wait_done(40);
        tick();
        chk("t6_issued",  64'(n_issued), 64'd5);
        chk("t6_status",  rd_status, {32'd5, 32'h62});
        chk("t6_q_empty", 64'(exp_q.size()), 64'd0);

        // reset pulsed mid-run
        n_issued = 0;
        wr_len(64'd50);
        push_idx(50);
        wr_ctrl(64'd1);
        repeat (3) tick();
        auto_rsp  = 1'b0;
        rsp_lines = '0;
        reset_n   = 1'b0;
        #1;
        chk("t7_rst_req_valid", {63'd0, req_valid}, 64'd0);
        chk("t7_rst_busy",      {63'd0, busy},      64'd0);
        exp_q.delete();
        tick();
        tick();
        reset_n = 1'b1;
        tick();
        chk("t7_status", rd_status, 64'd0);
        chk("t7_cycles", rd_cycles, 64'd0);

        // lines in IDLE are flagged but not counted
        rsp_lines = 3'd1;
        tick();
        rsp_lines = '0;
        tick();
        chk("t8_idle_rsp", rd_status, 64'h10);

        // reset cleared the length, so a start completes immediately
        wr_ctrl(64'd1);
        chk("t8_len_reset", {63'd0, done}, 64'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
